seq_mult_ctrl: RTL and testbench

//  Parametrised control FSM for the shift/add sequential multiplier datapath.
//  - Supports any operand WIDTH, unsigned or Booth radix-2 signed mode, selected per operation.
//  - Optional early exit when the remaining multiplier bits are zero.
//  - Valid/ready handshakes on both the operand side and the result side.
//  - Drives the product-register datapath: load, add, subtract, shift and final alignment shift.

---
 rtl/mult_pkg.sv | 18 +
 rtl/booth_decode.sv | 32 +++
 rtl/seq_mult_ctrl.sv | 113 +++++++++++
 tb/tb_seq_mult_ctrl.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types for the sequential multiplier.
// Controller states and Booth recoding operations.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_e;

endpackage

// File: rtl/booth_decode.sv
// Per-iteration add/subtract decode.
// Unsigned: add on q0. Booth radix-2: recode {q0,qm1}.
import mult_pkg::*;

module booth_decode (
  input  logic q0,
  input  logic qm1,
  input  logic mode,
  output logic add_en,
  output logic sub_en
);

  booth_op_e op;

  // Select the operation for the current multiplier bit pair
  always_comb begin
    op = BOOTH_NOP;
    unique case (1'b1)
      !mode: op = q0 ? BOOTH_ADD : BOOTH_NOP;
      mode: begin
        case ({q0, qm1})
          2'b01:   op = BOOTH_ADD;
          2'b10:   op = BOOTH_SUB;
          default: op = BOOTH_NOP;
        endcase
      end
    endcase
    add_en = (op == BOOTH_ADD);
    sub_en = (op == BOOTH_SUB);
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the shift/add multiplier datapath.
// Owns the iteration count, handshakes and early exit.
import mult_pkg::*;

module seq_mult_ctrl #(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic signed_in,
  input  logic flush,
  input  logic q0,
  input  logic qm1,
  input  logic rest_zero,
  output logic load,
  output logic add_en,
  output logic sub_en,
  output logic shift_en,
  output logic align_en,
  output logic [$clog2(WIDTH+1)-1:0] align_amt,
  output logic mode_q,
  output logic out_valid,
  input  logic out_ready
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic EE_ON = (EARLY_EXIT != 0);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mode_d;
  logic            bd_add, bd_sub;
  logic            run, early;

  booth_decode u_booth (
    .q0     (q0),
    .qm1    (qm1),
    .mode   (mode_q),
    .add_en (bd_add),
    .sub_en (bd_sub)
  );

  // Output decode; early exit suppresses the normal iteration
  always_comb begin
    run = (state_q == ST_RUN);
    early = EE_ON && run && rest_zero
          && (cnt_q < LAST)
          && (!mode_q || !qm1);
    in_ready  = (state_q == ST_IDLE);
    load      = (state_q == ST_LOAD);
    out_valid = (state_q == ST_DONE);
    shift_en  = run && !early;
    add_en    = run && !early && bd_add;
    sub_en    = run && !early && bd_sub;
    align_en  = early;
    align_amt = early ? (FULL - cnt_q) : '0;
  end

  // Next state, count and mode; flush overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            mode_d  = signed_in;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (early) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: behavioural datapath plus
// arithmetic reference for products, latency and op sequence.
module tb_seq_mult_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic clk = 1'b0;
  logic reset, in_valid, signed_in, flush;
  logic q0, qm1, rest_zero, out_ready;
  logic in_ready, load, add_en, sub_en;
  logic shift_en, align_en, mode_q, out_valid;
  logic [CW-1:0] align_amt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] op_a, op_b;
  logic [W:0]   ma;
  logic [W-1:0] mq, mm, mrem;
  logic         mqm1;

  always #5 clk = ~clk;

  seq_mult_ctrl #(.WIDTH(W), .EARLY_EXIT(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .signed_in (signed_in),
    .flush     (flush),
    .q0        (q0),
    .qm1       (qm1),
    .rest_zero (rest_zero),
    .load      (load),
    .add_en    (add_en),
    .sub_en    (sub_en),
    .shift_en  (shift_en),
    .align_en  (align_en),
    .align_amt (align_amt),
    .mode_q    (mode_q),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign q0        = mq[0];
  assign qm1       = mqm1;
  assign rest_zero = (mrem == '0);

  // Product register datapath obeying the controller
  always @(posedge clk) begin : dp
    logic [W:0]   ext, t;
    logic [2*W:0] p;
    ext = mode_q ? {mm[W-1], mm} : {1'b0, mm};
    if (load) begin
      ma   <= '0;
      mq   <= op_b;
      mqm1 <= 1'b0;
      mm   <= op_a;
      mrem <= op_b;
    end else if (align_en) begin
      p = {ma, mq};
      if (mode_q) p = $signed(p) >>> align_amt;
      else        p = p >> align_amt;
      ma <= p[2*W:W];
      mq <= p[W-1:0];
    end else if (shift_en) begin
      t = ma;
      if (add_en) t = ma + ext;
      if (sub_en) t = ma - ext;
      p = {t, mq};
      if (mode_q) p = $signed(p) >>> 1;
      else        p = p >> 1;
      ma   <= p[2*W:W];
      mq   <= p[W-1:0];
      mqm1 <= mq[0];
      mrem <= mrem >> 1;
    end
  end

  // Iteration index at which early exit fires, W if never
  function automatic int exp_k(logic [W-1:0] b, logic sgn);
    for (int n = 0; n <= W-2; n++) begin
      if ((b >> n) == '0) begin
        if (!sgn || n == 0) return n;
        if (b[n-1] == 1'b0) return n;
      end
    end
    return W;
  endfunction

  // Expected {sub,add} for iteration i
  function automatic logic [1:0] exp_op(logic [W-1:0] b, logic sgn,
                                        int i);
    logic cur, prev;
    cur  = b[i];
    prev = (i == 0) ? 1'b0 : b[i-1];
    if (!sgn) return {1'b0, cur};
    return {cur & ~prev, ~cur & prev};
  endfunction

  function automatic logic [2*W-1:0] exp_prod(logic [W-1:0] a,
                                              logic [W-1:0] b,
                                              logic sgn);
    int r;
    if (sgn) r = int'($signed(a)) * int'($signed(b));
    else     r = int'(a) * int'(b);
    return r[2*W-1:0];
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sgn, input int hold,
                       input string nm, output int lat,
                       output logic [2*W-1:0] prod);
    int k, nsh, nal, exp_lat, exp_sh, exp_al;
    logic seq_ok, amt_ok;
    logic [1:0] eo;
    k = exp_k(b, sgn);
    exp_lat = (k < W) ? k + 2 : W + 1;
    exp_sh  = (k < W) ? k : W;
    exp_al  = (k < W) ? 1 : 0;
    @(negedge clk);
    op_a = a; op_b = b; signed_in = sgn;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1; nsh = 0; nal = 0;
    seq_ok = 1'b1; amt_ok = 1'b1;
    for (int e = 1; e <= W + 4; e++) begin
      @(negedge clk);
      if (shift_en) begin
        eo = (nsh < W) ? exp_op(b, sgn, nsh) : 2'b11;
        if ({sub_en, add_en} !== eo) seq_ok = 1'b0;
        nsh++;
      end
      if (align_en) begin
        nal++;
        if (align_amt !== CW'(W - k)) amt_ok = 1'b0;
        if (shift_en | add_en | sub_en) amt_ok = 1'b0;
      end
      @(posedge clk); #1;
      if (out_valid) begin
        lat = e;
        break;
      end
    end
    prod = {ma[W-1:0], mq};
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, lat, exp_lat);
    end
    checks++;
    if (nsh != exp_sh || nal != exp_al) begin
      errors++;
      $display("FAIL %s iter count: shifts %0d/%0d aligns %0d/%0d",
               nm, nsh, exp_sh, nal, exp_al);
    end
    checks++;
    if (!seq_ok || !amt_ok) begin
      errors++;
      $display("FAIL %s op sequence: seq_ok=%0b amt_ok=%0b want 1/1",
               nm, seq_ok, amt_ok);
    end
    checks++;
    if (prod !== exp_prod(a, b, sgn)) begin
      errors++;
      $display("FAIL %s product: got %h want %h",
               nm, prod, exp_prod(a, b, sgn));
    end
    checks++;
    if (in_ready !== 1'b0 || mode_q !== sgn) begin
      errors++;
      $display("FAIL %s done flags: in_ready=%b mode_q=%b want 0/%b",
               nm, in_ready, mode_q, sgn);
    end
    if (hold > 0) begin
      out_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s hold: out_valid=%b in_ready=%b want 1/0",
                   nm, out_valid, in_ready);
        end
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s release: in_ready=%b out_valid=%b want 1/0",
               nm, in_ready, out_valid);
    end
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if ({in_ready, load, add_en, sub_en, shift_en, align_en,
         mode_q, out_valid} !== 8'b1000_0000 || align_amt !== '0) begin
      errors++;
      $display("FAIL %s idle outputs: got %b amt %0d want 10000000 amt 0",
               nm, {in_ready, load, add_en, sub_en, shift_en,
                    align_en, mode_q, out_valid}, align_amt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unsigned_b5();
    int lat;
    logic [2*W-1:0] prod;
    do_op(W'($urandom), 8'hB5, 1'b0, 0, "unsigned_b5", lat, prod);
    checks++;
    if (lat != 9) begin
      errors++;
      $display("FAIL unsigned_b5 edge: got %0d want 9", lat);
    end
  endtask

  task automatic test_booth();
    int lat;
    logic [2*W-1:0] prod;
    do_op(8'd7, 8'hFD, 1'b1, 0, "booth_m3", lat, prod);
    checks++;
    if (prod !== 16'hFFEB) begin
      errors++;
      $display("FAIL booth_m3 const: got %h want ffeb", prod);
    end
  endtask

  task automatic test_early_exit();
    int lat;
    logic [2*W-1:0] prod;
    do_op(W'($urandom), 8'h03, 1'b0, 0, "early", lat, prod);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL early edge: got %0d want 4", lat);
    end
  endtask

  task automatic test_done_hold();
    int lat;
    logic [2*W-1:0] prod;
    do_op(W'($urandom), W'($urandom), 1'($urandom), 5,
          "done_hold", lat, prod);
  endtask

  task automatic test_flush();
    logic seen;
    logic [W-1:0] a2, b2;
    seen = 1'b0;
    @(negedge clk);
    op_a = W'($urandom); op_b = 8'hFF;
    signed_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (shift_en !== 1'b1) begin
      errors++;
      $display("FAIL flush pre: shift_en=%b want 1", shift_en);
    end
    @(negedge clk);
    flush = 1'b1; signed_in = 1'b1;
    @(posedge clk); #1;
    if (out_valid) seen = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || load !== 1'b0 || mode_q !== 1'b0) begin
      errors++;
      $display("FAIL flush idle: rdy=%b load=%b mode=%b want 1/0/0",
               in_ready, load, mode_q);
    end
    a2 = W'($urandom); b2 = W'($urandom) | 8'h80;
    @(negedge clk);
    flush = 1'b0; op_a = a2; op_b = b2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (load !== 1'b1 || mode_q !== 1'b1) begin
      errors++;
      $display("FAIL flush reaccept: load=%b mode=%b want 1/1",
               load, mode_q);
    end
    for (int e = 1; e <= W + 4; e++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    checks++;
    if (out_valid !== 1'b1 ||
        {ma[W-1:0], mq} !== exp_prod(a2, b2, 1'b1)) begin
      errors++;
      $display("FAIL flush result: ov=%b got %h want %h", out_valid,
               {ma[W-1:0], mq}, exp_prod(a2, b2, 1'b1));
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL flush no_valid: seen=%b want 0", seen);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [2*W-1:0] prod;
    @(negedge clk);
    op_a = W'($urandom); op_b = W'($urandom);
    signed_in = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (load !== 1'b1) begin
      errors++;
      $display("FAIL rst_load pre: load=%b want 1", load);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_idle("rst_load");
    @(negedge clk);
    reset = 1'b0;
    op_b = 8'h01; signed_in = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int e = 1; e <= W + 4; e++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_done pre: out_valid=%b want 1", out_valid);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_idle("rst_done");
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    do_op(W'($urandom), 8'hC3, 1'b0, 0, "post_reset", lat, prod);
  endtask

  task automatic test_back_to_back();
    int lat, hold;
    logic [W-1:0] a, b;
    logic sgn;
    logic [2*W-1:0] prod;
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      if ($urandom_range(0, 2) == 0) b = W'($urandom_range(0, 15));
      else b = W'($urandom);
      sgn = 1'($urandom_range(0, 1));
      hold = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
      do_op(a, b, sgn, hold, "random", lat, prod);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; signed_in = 1'b0;
    flush = 1'b0; out_ready = 1'b1;
    op_a = '0; op_b = '0;
    ma = '0; mq = '0; mm = '0; mrem = '0; mqm1 = 1'b0;
    test_reset();
    test_unsigned_b5();
    test_booth();
    test_early_exit();
    test_done_hold();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
